uram_sdp_pipe: RTL and testbench
================================

# uram_sdp_pipe

Parameterised UltraRAM simple-dual-port memory with byte-write enables, a selectable read-during-write mode, and a credit-controlled read path. A read is never lost under output backpressure. Read data flows through an NBPIPE-deep enable-tracked pipeline into an internal first-word-fall-through queue. Sits wherever a deep on-chip table or buffer must feed a ready/valid consumer that can stall.

## Interface
- AWIDTH, 12, address width; depth = 2^AWIDTH words
- DWIDTH, 72, data width; must be a multiple of 8
- NBPIPE, 3, read pipeline registers after the RAM output register; ≥1
- RDW_MODE, 0, same-address same-cycle read/write: 0 = old data, 1 = new data (byte-merged)
- QDEPTH, NBPIPE+3, output queue depth and read-credit count; ≥ NBPIPE+2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; memory array is not reset
- wr_en  in  1  write strobe
- wr_be  in  DWIDTH/8  byte enables; bit k covers wr_data[8k+7:8k]
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- rd_req  in  1  read request
- rd_addr  in  AWIDTH  read address
- rd_rdy  out  1  request accepted this cycle if rd_req also high
- rd_vld  out  1  queue head valid
- rd_data  out  DWIDTH  queue head data
- rd_ack  in  1  consumer takes head when rd_vld high

## Operation
- Write: on an edge with wr_en, bytes with wr_be[k]=1 update mem[wr_addr]; wr_be=0 leaves the word unchanged.
- Read accept: an edge with rd_req && rd_rdy. The RAM is read at that edge. A tag bit enters the enable pipeline (memreg stage + NBPIPE stages); data stages load only when their tag is set.
- RDW_MODE=1 with an accepted read and wr_en, wr_addr==rd_addr on the same edge:
  - The forwarding flag, wr_data and wr_be are registered alongside memreg.
  - Stage-0 data = memreg with enabled bytes replaced by wr_data.
  - RDW_MODE=0 returns the pre-write word.
- Writes on later edges never alter a read already accepted.
- Credits: counter cnt, range 0..QDEPTH.
  - Accept only: cnt−1. Pop only (rd_vld && rd_ack): cnt+1. Both or neither: unchanged.
  - rd_rdy = (cnt != 0).
  - The queue can therefore never overflow. Data is never dropped or overwritten.
- Queue: FIFO of QDEPTH entries, written when the last pipe stage's tag is set.
  - rd_vld = not empty; rd_data = head entry.
  - Pop on rd_vld && rd_ack.
  - rd_ack with rd_vld low is ignored.
- Empty-queue arrival with same-cycle rd_ack: the data is still written first and appears on rd_vld next cycle (no bypass).

## Timing
- Reset values: rd_rdy=1 once rst_n deasserts (cnt=QDEPTH), rd_vld=0, rd_data=0. Pipeline tags, queue pointers and the forward flag are cleared.
- Reset mid-operation discards all in-flight and queued reads; memory contents are retained.
- Latency: a read accepted at edge E is written into the queue at edge E+NBPIPE+1. rd_vld is high in the following cycle: NBPIPE+2 cycles from request to data.
- With rd_ack held high and QDEPTH ≥ NBPIPE+3, one read per cycle is sustained indefinitely.
- Queue order equals request order.
- cnt full → rd_rdy=1. cnt zero → rd_rdy=0 until the first pop edge; rd_rdy rises the cycle after that edge.
- Queue wrap-around: pointers are modulo QDEPTH; full/empty are distinguished by an occupancy count.
- Write latency is one edge: a read accepted at edge E+1 sees a write made at edge E.

## Test plan
- Write 0x1122334455667788AA to addr 5 with wr_be all-ones, then read addr 5 with rd_ack=1 → rd_vld exactly 5 cycles after the request cycle (NBPIPE=3) with that value; the stall counter stays 0.
- Addr 7 holds 0x00…00. In the same cycle, write 0xFF…FF with wr_be=0x001 and read addr 7:
  - RDW_MODE=0 → 0x00…00
  - RDW_MODE=1 → 0x0000…00FF
- Backpressure: rd_ack=0, issue 10 back-to-back reads of addrs 0..9 → rd_rdy drops after exactly QDEPTH=6 accepts. Then raise rd_ack → data for 0..5 in order, then 6..9, with no loss or duplication.
- Streaming: rd_ack=1, rd_req=1 for 1000 cycles over sequential addresses → rd_rdy never drops and rd_vld is continuous once primed.
- Assert rst_n=0 for 1 cycle with 3 reads in flight and 2 queued → rd_vld=0, rd_rdy=1 next cycle, no stale data ever emerges. Re-reading an address written earlier returns its pre-reset value.
- Randomised wr_be and writes to the same address as outstanding reads → every returned word matches a reference model that snapshots memory at the accept edge.

Source files
------------

// File: rtl/uram_sdp_pipe.sv
// Byte-writable SDP RAM whose reads flow memreg -> NBPIPE tagged stages -> FWFT queue.
// Read latency is NBPIPE+2 cycles; read credits stop requests before the queue can overflow, so no read is ever lost.
module uram_sdp_pipe #(
    parameter int AWIDTH   = 12,
    parameter int DWIDTH   = 72,
    parameter int NBPIPE   = 3,
    parameter int RDW_MODE = 0,
    parameter int QDEPTH   = NBPIPE + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DWIDTH/8-1:0]   wr_be,
    input  logic [AWIDTH-1:0]     wr_addr,
    input  logic [DWIDTH-1:0]     wr_data,
    input  logic                  rd_req,
    input  logic [AWIDTH-1:0]     rd_addr,
    output logic                  rd_rdy,
    output logic                  rd_vld,
    output logic [DWIDTH-1:0]     rd_data,
    input  logic                  rd_ack
);
    localparam int NB = DWIDTH / 8;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    logic              accept, pop, push;
    logic [DWIDTH-1:0] memreg_q;
    logic              memtag_q;
    logic              fwd_q;
    logic [DWIDTH-1:0] fwd_data_q;
    logic [NB-1:0]     fwd_be_q;
    logic [DWIDTH-1:0] stage0_d;
    logic [DWIDTH-1:0] pipe_dat_q [NBPIPE];
    logic [NBPIPE-1:0] pipe_tag_q, pipe_tag_d;
    logic [DWIDTH-1:0] q_mem_q [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_rdy  = (cnt_q != '0);
    assign rd_vld  = (occ_q != '0);
    assign rd_data = q_mem_q[rd_ptr_q];
    assign accept  = rd_req && rd_rdy;
    assign pop     = rd_vld && rd_ack;
    assign push    = pipe_tag_q[NBPIPE-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // The array read samples pre-write contents; new-data mode merges the colliding write afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            memreg_q   <= mem[rd_addr];
            fwd_data_q <= wr_data;
            fwd_be_q   <= wr_be;
        end
        if (memtag_q) pipe_dat_q[0] <= stage0_d;
        for (int i = 1; i < NBPIPE; i++) begin
            if (pipe_tag_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
        end
    end

    always_comb begin
        stage0_d = memreg_q;
        if (fwd_q) begin
            for (int k = 0; k < NB; k++) begin
                if (fwd_be_q[k]) stage0_d[8*k +: 8] = fwd_data_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        pipe_tag_d    = '0;
        pipe_tag_d[0] = memtag_q;
        for (int i = 1; i < NBPIPE; i++) pipe_tag_d[i] = pipe_tag_q[i-1];
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + CW'(1);
        else if (!push && pop) occ_d = occ_q - CW'(1);
        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q - CW'(1);
        else if (!accept && pop) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memtag_q   <= 1'b0;
            fwd_q      <= 1'b0;
            pipe_tag_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            cnt_q      <= CW'(QDEPTH);
            for (int i = 0; i < QDEPTH; i++) q_mem_q[i] <= '0;
        end else begin
            memtag_q   <= accept;
            fwd_q      <= accept && wr_en && (wr_addr == rd_addr) && (RDW_MODE == 1);
            pipe_tag_q <= pipe_tag_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            if (push) begin
                q_mem_q[wr_ptr_q] <= pipe_dat_q[NBPIPE-1];
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end
endmodule

// File: tb/tb_uram_sdp_pipe.sv
// Directed bench for uram_sdp_pipe: one old-data and one new-data instance share all stimulus.
module tb_uram_sdp_pipe;
    localparam logic [71:0] V5 = 72'h11_2233_4455_6677_88AA;

    logic        clk = 1'b0;
    logic        rst_n, wr_en, rd_req, rd_ack;
    logic [8:0]  wr_be;
    logic [11:0] wr_addr, rd_addr;
    logic [71:0] wr_data;
    logic        rd_rdy0, rd_vld0, rd_rdy1, rd_vld1;
    logic [71:0] rd_data0, rd_data1;

    int total = 0;
    int bad   = 0;
    logic [71:0] ref_mem [64];
    logic [71:0] sb0 [$];
    logic [71:0] sb1 [$];

    always #5 clk = ~clk;

    uram_sdp_pipe #(.RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy0),
        .rd_vld(rd_vld0), .rd_data(rd_data0), .rd_ack(rd_ack)
    );
    uram_sdp_pipe #(.RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy1),
        .rd_vld(rd_vld1), .rd_data(rd_data1), .rd_ack(rd_ack)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] pat(input int a);
        return {8'(a), 64'h0123_4567_89AB_CDEF + 64'(a)};
    endfunction

    function automatic logic [71:0] merge(input logic [71:0] old, input logic [71:0] nw, input logic [8:0] be);
        logic [71:0] r = old;
        for (int k = 0; k < 9; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b1; wr_en = 0; wr_be = '0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0; rd_ack = 0;
        #2 rst_n = 1'b0;
        step; step;
        rst_n = 1'b1;
        step;
        total++; if (rd_rdy0 !== 1'b1) begin bad++; $display("FAIL reset_rdy0: got %b expected 1", rd_rdy0); end
        total++; if (rd_vld0 !== 1'b0) begin bad++; $display("FAIL reset_vld0: got %b expected 0", rd_vld0); end
        total++; if (rd_data0 !== 72'h0) begin bad++; $display("FAIL reset_data0: got %h expected 0", rd_data0); end
        total++; if (rd_rdy1 !== 1'b1) begin bad++; $display("FAIL reset_rdy1: got %b expected 1", rd_rdy1); end
        total++; if (rd_vld1 !== 1'b0) begin bad++; $display("FAIL reset_vld1: got %b expected 0", rd_vld1); end
    endtask

    task automatic init_mem;
        for (int a = 0; a < 64; a++) begin
            wr_en = 1; wr_be = 9'h1FF; wr_addr = 12'(a); wr_data = pat(a);
            ref_mem[a] = pat(a);
            step;
        end
        wr_en = 0;
    endtask

    task automatic test_write_read;
        int lat, stall;
        wr_en = 1; wr_be = 9'h1FF; wr_addr = 12'd5; wr_data = V5; ref_mem[5] = V5;
        step;
        wr_en = 0; rd_req = 1; rd_addr = 12'd5; rd_ack = 1;
        stall = rd_rdy0 ? 0 : 1;
        step;
        rd_req = 0; lat = 1;
        while (!rd_vld0 && lat < 20) begin step; lat++; end
        total++; if (lat != 5) begin bad++; $display("FAIL wr_rd_latency: got %0d expected 5", lat); end
        total++; if (rd_data0 !== V5) begin bad++; $display("FAIL wr_rd_data0: got %h expected %h", rd_data0, V5); end
        total++; if (rd_data1 !== V5) begin bad++; $display("FAIL wr_rd_data1: got %h expected %h", rd_data1, V5); end
        total++; if (stall != 0) begin bad++; $display("FAIL wr_rd_stall: got %0d expected 0", stall); end
        step;
        total++; if (rd_vld0 !== 1'b0) begin bad++; $display("FAIL wr_rd_popped: got %b expected 0", rd_vld0); end
    endtask

    task automatic test_rdw;
        int n;
        wr_en = 1; wr_be = 9'h1FF; wr_addr = 12'd7; wr_data = '0; ref_mem[7] = '0;
        step;
        wr_be = 9'h001; wr_data = '1; rd_req = 1; rd_addr = 12'd7; rd_ack = 1;
        step;
        rd_req = 0; wr_be = 9'h1FF;
        step;
        wr_en = 0; ref_mem[7] = '1; n = 0;
        while (!rd_vld0 && n < 20) begin step; n++; end
        total++; if (!rd_vld0 || !rd_vld1) begin bad++; $display("FAIL rdw_timeout: got vld %b%b expected 11", rd_vld0, rd_vld1); end
        total++; if (rd_data0 !== 72'h0) begin bad++; $display("FAIL rdw_old: got %h expected 0", rd_data0); end
        total++; if (rd_data1 !== 72'hFF) begin bad++; $display("FAIL rdw_new: got %h expected ff", rd_data1); end
        step;
        rd_req = 1; rd_addr = 12'd7;
        step;
        rd_req = 0; n = 0;
        while (!rd_vld0 && n < 20) begin step; n++; end
        total++; if (rd_data0 !== {72{1'b1}}) begin bad++; $display("FAIL rdw_reread0: got %h expected all ones", rd_data0); end
        total++; if (rd_data1 !== {72{1'b1}}) begin bad++; $display("FAIL rdw_reread1: got %h expected all ones", rd_data1); end
        step;
    endtask

    task automatic test_backpressure;
        int nxt = 0, popped = 0;
        bit first = 1;
        rd_ack = 0;
        for (int c = 0; c < 10; c++) begin
            rd_req = 1; rd_addr = 12'(nxt);
            if (rd_rdy0) begin sb0.push_back(ref_mem[nxt]); nxt++; end
            step;
        end
        total++; if (nxt != 6) begin bad++; $display("FAIL bp_accepts: got %0d expected 6", nxt); end
        total++; if (rd_rdy0 !== 1'b0) begin bad++; $display("FAIL bp_rdy_low: got %b expected 0", rd_rdy0); end
        total++; if (rd_vld0 !== 1'b1) begin bad++; $display("FAIL bp_vld: got %b expected 1", rd_vld0); end
        rd_ack = 1;
        for (int c = 0; c < 60 && popped < 10; c++) begin
            rd_req = (nxt < 10); rd_addr = 12'(nxt);
            if (rd_req && rd_rdy0) begin sb0.push_back(ref_mem[nxt]); nxt++; end
            if (rd_vld0) begin
                total++;
                if (sb0.size() == 0) begin bad++; $display("FAIL bp_extra: got %h expected nothing", rd_data0); end
                else if (rd_data0 !== sb0[0]) begin bad++; $display("FAIL bp_data: got %h expected %h", rd_data0, sb0[0]); end
                if (sb0.size() != 0) void'(sb0.pop_front());
                popped++;
            end
            step;
            if (first) begin
                total++; if (rd_rdy0 !== 1'b1) begin bad++; $display("FAIL bp_rdy_rise: got %b expected 1", rd_rdy0); end
                first = 0;
            end
        end
        rd_req = 0;
        total++; if (popped != 10 || sb0.size() != 0) begin bad++; $display("FAIL bp_count: got %0d expected 10", popped); end
    endtask

    task automatic test_stream;
        int rdrop = 0, gaps = 0, popped = 0;
        bit primed = 0;
        rd_ack = 1;
        for (int c = 0; c < 1020; c++) begin
            rd_req = (c < 1000); rd_addr = 12'(c % 64);
            if (rd_req) begin
                if (!rd_rdy0) rdrop++;
                else sb0.push_back(ref_mem[c % 64]);
            end
            if (rd_vld0) begin
                primed = 1; popped++;
                total++;
                if (sb0.size() == 0) begin bad++; $display("FAIL stream_extra: got %h expected nothing", rd_data0); end
                else if (rd_data0 !== sb0[0]) begin bad++; $display("FAIL stream_data: got %h expected %h", rd_data0, sb0[0]); end
                if (sb0.size() != 0) void'(sb0.pop_front());
            end else if (primed && c < 1000) gaps++;
            step;
        end
        rd_req = 0;
        total++; if (rdrop != 0) begin bad++; $display("FAIL stream_rdy_drop: got %0d expected 0", rdrop); end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
        total++; if (popped != 1000) begin bad++; $display("FAIL stream_count: got %0d expected 1000", popped); end
    endtask

    task automatic test_reset_midop;
        int leak = 0, n = 0;
        rd_ack = 0;
        for (int i = 0; i < 5; i++) begin rd_req = 1; rd_addr = 12'(10 + i); step; end
        rd_req = 0;
        step;
        total++; if (rd_vld0 !== 1'b1) begin bad++; $display("FAIL midrst_queued: got %b expected 1", rd_vld0); end
        rst_n = 0;
        #1;
        total++; if (rd_vld0 !== 1'b0) begin bad++; $display("FAIL midrst_vld: got %b expected 0", rd_vld0); end
        total++; if (rd_rdy0 !== 1'b1) begin bad++; $display("FAIL midrst_rdy: got %b expected 1", rd_rdy0); end
        step;
        rst_n = 1; rd_ack = 1;
        for (int c = 0; c < 15; c++) begin
            if (rd_vld0 || rd_vld1) leak++;
            step;
        end
        total++; if (leak != 0) begin bad++; $display("FAIL midrst_stale: got %0d expected 0", leak); end
        rd_req = 1; rd_addr = 12'd5;
        step;
        rd_req = 0;
        while (!rd_vld0 && n < 20) begin step; n++; end
        total++; if (rd_data0 !== V5) begin bad++; $display("FAIL midrst_retain: got %h expected %h", rd_data0, V5); end
        step;
    endtask

    task automatic test_random;
        int acc = 0, popped = 0, ra, wa;
        logic [71:0] old;
        for (int c = 0; c < 330; c++) begin
            bit live = (c < 300);
            ra = $urandom_range(0, 3); wa = $urandom_range(0, 3);
            rd_req  = live && ($urandom_range(0, 9) < 7);
            rd_addr = 12'(ra);
            rd_ack  = ($urandom_range(0, 3) != 0);
            wr_en   = live && ($urandom_range(0, 1) == 1);
            wr_addr = 12'(wa);
            wr_be   = 9'($urandom());
            wr_data = {8'($urandom()), $urandom(), $urandom()};
            if (rd_vld0 && rd_ack) begin
                popped++; total++;
                if (sb0.size() == 0) begin bad++; $display("FAIL rnd_extra0: got %h expected nothing", rd_data0); end
                else if (rd_data0 !== sb0[0]) begin bad++; $display("FAIL rnd_data0: got %h expected %h", rd_data0, sb0[0]); end
                if (sb0.size() != 0) void'(sb0.pop_front());
            end
            if (rd_vld1 && rd_ack) begin
                total++;
                if (sb1.size() == 0) begin bad++; $display("FAIL rnd_extra1: got %h expected nothing", rd_data1); end
                else if (rd_data1 !== sb1[0]) begin bad++; $display("FAIL rnd_data1: got %h expected %h", rd_data1, sb1[0]); end
                if (sb1.size() != 0) void'(sb1.pop_front());
            end
            old = ref_mem[ra];
            if (rd_req && rd_rdy0) begin sb0.push_back(old); acc++; end
            if (rd_req && rd_rdy1)
                sb1.push_back((wr_en && wa == ra) ? merge(old, wr_data, wr_be) : old);
            if (wr_en) ref_mem[wa] = merge(ref_mem[wa], wr_data, wr_be);
            step;
        end
        wr_en = 0; rd_req = 0;
        total++; if (popped != acc || sb0.size() != 0 || sb1.size() != 0)
            begin bad++; $display("FAIL rnd_count: got %0d popped expected %0d", popped, acc); end
    endtask

    initial begin
        test_reset;
        init_mem;
        test_write_read;
        test_rdw;
        test_backpressure;
        test_stream;
        test_reset_midop;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
